// File: rtl/imm_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imm_gen_pkg
// Purpose  : Shared types and opcode constants for the immediate-generation
//            stage (format codes, pipeline states, RISC-V major opcodes).
// Revision : 1.0 - initial release
// ============================================================================
package imm_gen_pkg;

    // Instruction format reported alongside the immediate
    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_NONE = 3'd7
    } fmt_e;

    // Occupancy of the output register / skid buffer pair
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_e;

    // RISC-V major opcodes (instr[6:0])
    localparam logic [6:0] c_OP_LOAD     = 7'b0000011;
    localparam logic [6:0] c_OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] c_OP_IMM      = 7'b0010011;
    localparam logic [6:0] c_OP_JALR     = 7'b1100111;
    localparam logic [6:0] c_OP_SYSTEM   = 7'b1110011;
    localparam logic [6:0] c_OP_IMM_32   = 7'b0011011;
    localparam logic [6:0] c_OP_STORE    = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] c_OP_LUI      = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] c_OP_JAL      = 7'b1101111;
    localparam logic [6:0] c_OP_REG      = 7'b0110011;
    localparam logic [6:0] c_OP_REG_32   = 7'b0111011;

endpackage
`default_nettype wire

// File: rtl/imm_decode.sv
`default_nettype none
// ============================================================================
// Module   : imm_decode
// Purpose  : Combinational opcode classifier and immediate builder. Produces
//            the sign-extended immediate, format code and illegal flag.
// Revision : 1.0 - initial release
// ============================================================================
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN            = 64,
    parameter int HALFWORD_BRANCH = 1
) (
    input  logic [31:0]     i_instr,
    output logic [XLEN-1:0] o_imm,
    output fmt_e            o_fmt,
    output logic            o_illegal
);

    localparam bit c_IS64 = (XLEN == 64);
    localparam bit c_HW   = (HALFWORD_BRANCH != 0);

    // Immediate assembled at 32 bits; bit 31 is always the sign source
    logic [31:0] w_imm32;

    // Classify the opcode and build the 32-bit sign-extended immediate
    always_comb begin
        w_imm32   = 32'd0;
        o_fmt     = FMT_NONE;
        o_illegal = 1'b0;
        case (i_instr[6:0])
            c_OP_LOAD, c_OP_MISC_MEM, c_OP_IMM, c_OP_JALR, c_OP_SYSTEM: begin
                o_fmt   = FMT_I;
                w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            end
            c_OP_IMM_32: begin
                if (c_IS64) begin
                    o_fmt   = FMT_I;
                    w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
                end else begin
                    o_illegal = 1'b1;
                end
            end
            c_OP_STORE: begin
                o_fmt   = FMT_S;
                w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            end
            c_OP_BRANCH: begin
                o_fmt = FMT_B;
                // Halfword mode drops the always-zero LSB and widens the sign
                if (c_HW) begin
                    w_imm32 = {{20{i_instr[31]}}, i_instr[31], i_instr[7],
                               i_instr[30:25], i_instr[11:8]};
                end else begin
                    w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                               i_instr[30:25], i_instr[11:8], 1'b0};
                end
            end
            c_OP_LUI, c_OP_AUIPC: begin
                o_fmt   = FMT_U;
                w_imm32 = {i_instr[31:12], 12'd0};
            end
            c_OP_JAL: begin
                o_fmt = FMT_J;
                if (c_HW) begin
                    w_imm32 = {{12{i_instr[31]}}, i_instr[31], i_instr[19:12],
                               i_instr[20], i_instr[30:21]};
                end else begin
                    w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                               i_instr[20], i_instr[30:21], 1'b0};
                end
            end
            c_OP_REG: begin
                o_fmt = FMT_R;
            end
            c_OP_REG_32: begin
                if (c_IS64) begin
                    o_fmt = FMT_R;
                end else begin
                    o_illegal = 1'b1;
                end
            end
            default: begin
                o_illegal = 1'b1;
            end
        endcase
    end

    // Widen to XLEN by replicating bit 31
    if (XLEN > 32) begin : g_sext
        assign o_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
    end else begin : g_narrow
        assign o_imm = w_imm32[XLEN-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module   : imm_gen_pipe
// Purpose  : Elastic immediate-generation stage. Decodes each instruction
//            combinationally and holds results in an output register backed
//            by a one-entry skid buffer (valid/ready, one-cycle latency).
// Revision : 1.0 - initial release
// ============================================================================
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN            = 64,
    parameter int HALFWORD_BRANCH = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    typedef struct packed {
        logic [XLEN-1:0] imm;
        fmt_e            fmt;
        logic            illegal;
    } res_t;

    logic [XLEN-1:0] w_dec_imm;
    fmt_e            w_dec_fmt;
    logic            w_dec_illegal;
    res_t            w_dec;

    pipe_state_e     r_state;
    pipe_state_e     w_state_nxt;
    res_t            r_out;
    res_t            r_skid;

    logic            w_accept;
    logic            w_deliver;
    logic            w_ld_out_in;
    logic            w_ld_out_skid;
    logic            w_ld_skid;

    imm_decode #(
        .XLEN            (XLEN),
        .HALFWORD_BRANCH (HALFWORD_BRANCH)
    ) u_decode (
        .i_instr   (in_instr),
        .o_imm     (w_dec_imm),
        .o_fmt     (w_dec_fmt),
        .o_illegal (w_dec_illegal)
    );

    assign w_dec = '{imm: w_dec_imm, fmt: w_dec_fmt, illegal: w_dec_illegal};

    // in_ready depends only on registered state and reset, never on out_ready
    assign in_ready  = !reset && (r_state != ST_FULL);
    assign out_valid = (r_state != ST_EMPTY);
    assign w_accept  = in_valid && in_ready;
    assign w_deliver = out_valid && out_ready;

    assign out_imm     = r_out.imm;
    assign out_fmt     = r_out.fmt;
    assign out_illegal = r_out.illegal;

    // Next occupancy and which register loads from where
    always_comb begin
        w_state_nxt   = r_state;
        w_ld_out_in   = 1'b0;
        w_ld_out_skid = 1'b0;
        w_ld_skid     = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_ld_out_in = 1'b1;
                    w_state_nxt = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_accept && w_deliver) begin
                    w_ld_out_in = 1'b1;
                end else if (w_accept) begin
                    w_ld_skid   = 1'b1;
                    w_state_nxt = ST_FULL;
                end else if (w_deliver) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_deliver) begin
                    w_ld_out_skid = 1'b1;
                    w_state_nxt   = ST_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    // Occupancy state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output and skid data registers; reset clears both to a neutral result
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out.imm      <= '0;
            r_out.fmt      <= FMT_NONE;
            r_out.illegal  <= 1'b0;
            r_skid.imm     <= '0;
            r_skid.fmt     <= FMT_NONE;
            r_skid.illegal <= 1'b0;
        end else begin
            if (w_ld_out_in) begin
                r_out <= w_dec;
            end else if (w_ld_out_skid) begin
                r_out <= r_skid;
            end
            if (w_ld_skid) begin
                r_skid <= w_dec;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_gen_pipe
// Purpose  : Self-checking bench for imm_gen_pipe. Two instances (XLEN=64 with
//            halfword branches, XLEN=32 with byte branches) share stimulus and
//            are compared against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        out_ready;

    logic        rdy64, vld64, ill64;
    logic [63:0] imm64;
    logic [2:0]  fmt64;
    logic        rdy32, vld32, ill32;
    logic [31:0] imm32;
    logic [2:0]  fmt32;

    int n_vec = 0;
    int n_err = 0;

    // Instructions accepted but not yet delivered, oldest first
    logic [31:0] q[$];

    logic [6:0] ops [13] = '{7'h03, 7'h0F, 7'h13, 7'h67, 7'h73, 7'h1B, 7'h23,
                             7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B};

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(64), .HALFWORD_BRANCH(1)) d64 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy64),
        .in_instr(in_instr), .out_valid(vld64), .out_ready(out_ready),
        .out_imm(imm64), .out_fmt(fmt64), .out_illegal(ill64)
    );

    imm_gen_pipe #(.XLEN(32), .HALFWORD_BRANCH(0)) d32 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy32),
        .in_instr(in_instr), .out_valid(vld32), .out_ready(out_ready),
        .out_imm(imm32), .out_fmt(fmt32), .out_illegal(ill32)
    );

    // Reference immediate as a signed integer offset, then viewed at XLEN
    function automatic logic [63:0] m_imm(input logic [31:0] ins, input bit x64, input bit hb);
        longint v = 0;
        case (ins[6:0])
            7'h03, 7'h0F, 7'h13, 7'h67, 7'h73: v = $signed(ins[31:20]);
            7'h1B: v = x64 ? longint'($signed(ins[31:20])) : 0;
            7'h23: v = $signed({ins[31:25], ins[11:7]});
            7'h63: begin
                v = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
                if (hb) v = v / 2;
            end
            7'h37, 7'h17: v = longint'($signed(ins[31:12])) * 4096;
            7'h6F: begin
                v = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
                if (hb) v = v / 2;
            end
            default: v = 0;
        endcase
        return x64 ? 64'(v) : {32'd0, v[31:0]};
    endfunction

    function automatic logic [2:0] m_fmt(input logic [31:0] ins, input bit x64);
        case (ins[6:0])
            7'h03, 7'h0F, 7'h13, 7'h67, 7'h73: return 3'd1;
            7'h1B:        return x64 ? 3'd1 : 3'd7;
            7'h23:        return 3'd2;
            7'h63:        return 3'd3;
            7'h37, 7'h17: return 3'd4;
            7'h6F:        return 3'd5;
            7'h33:        return 3'd0;
            7'h3B:        return x64 ? 3'd0 : 3'd7;
            default:      return 3'd7;
        endcase
    endfunction

    function automatic logic m_ill(input logic [31:0] ins, input bit x64);
        return m_fmt(ins, x64) == 3'd7;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare both instances against the model's view of the pipeline
    task automatic check_outputs();
        logic exp_rdy, exp_vld;
        exp_rdy = (q.size() < 2);
        exp_vld = (q.size() != 0);
        chk("in_ready64", 64'(rdy64), 64'(exp_rdy));
        chk("in_ready32", 64'(rdy32), 64'(exp_rdy));
        chk("out_valid64", 64'(vld64), 64'(exp_vld));
        chk("out_valid32", 64'(vld32), 64'(exp_vld));
        if (q.size() != 0) begin
            chk("imm64", imm64, m_imm(q[0], 1'b1, 1'b1));
            chk("fmt64", 64'(fmt64), 64'(m_fmt(q[0], 1'b1)));
            chk("ill64", 64'(ill64), 64'(m_ill(q[0], 1'b1)));
            chk("imm32", {32'd0, imm32}, m_imm(q[0], 1'b0, 1'b0));
            chk("fmt32", 64'(fmt32), 64'(m_fmt(q[0], 1'b0)));
            chk("ill32", 64'(ill32), 64'(m_ill(q[0], 1'b0)));
        end
    endtask

    // One clock of traffic: drive, check mid-cycle, advance the model at the edge
    task automatic step(input logic v, input logic [31:0] ins, input logic rdy);
        logic acc, dlv;
        in_valid  = v;
        in_instr  = ins;
        out_ready = rdy;
        @(negedge clk);
        check_outputs();
        acc = v && (q.size() < 2);
        dlv = rdy && (q.size() != 0);
        @(posedge clk);
        if (dlv) void'(q.pop_front());
        if (acc) q.push_back(ins);
        #1;
    endtask

    // Two reset cycles with junk on the inputs; outputs must return to neutral
    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_instr  = $urandom;
        out_ready = 1'($urandom);
        @(negedge clk);
        chk("rst_in_ready64", 64'(rdy64), 64'd0);
        chk("rst_in_ready32", 64'(rdy32), 64'd0);
        @(posedge clk);
        q.delete();
        #1;
        in_instr = $urandom;
        @(negedge clk);
        chk("rst_valid64", 64'(vld64), 64'd0);
        chk("rst_valid32", 64'(vld32), 64'd0);
        chk("rst_imm64", imm64, 64'd0);
        chk("rst_imm32", {32'd0, imm32}, 64'd0);
        chk("rst_fmt64", 64'(fmt64), 64'd7);
        chk("rst_fmt32", 64'(fmt32), 64'd7);
        chk("rst_ill64", 64'(ill64), 64'd0);
        chk("rst_ill32", 64'(ill32), 64'd0);
        chk("rst_in_ready64b", 64'(rdy64), 64'd0);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 3) != 0) r[6:0] = ops[$urandom_range(0, 12)];
        return r;
    endfunction

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
        do_reset();

        // Directed decode cases with a free-flowing consumer
        step(1'b1, 32'hFFF0_0093, 1'b1);   // addi x1,x0,-1
        step(1'b1, 32'hFE00_0E63, 1'b1);   // branch, negative offset
        step(1'b1, 32'hFE00_0EE3, 1'b1);   // beq -4
        step(1'b1, 32'h8000_02B7, 1'b1);   // lui 0x80000
        step(1'b1, 32'h0000_0000, 1'b1);   // illegal (low bits 00)
        step(1'b1, 32'h0000_001B, 1'b1);   // addiw: legal only at XLEN=64
        step(1'b1, 32'hFE11_2E23, 1'b1);   // store
        step(1'b1, 32'hFFDF_F06F, 1'b1);   // jal negative
        step(1'b1, 32'h0000_803B, 1'b1);   // R-type 32-bit op
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);

        // Back-pressure: A, B accepted, C held until the consumer drains
        step(1'b1, 32'h0010_0093, 1'b0);
        step(1'b1, 32'h8000_0317, 1'b0);
        step(1'b1, 32'h0040_006F, 1'b0);
        step(1'b1, 32'h0040_006F, 1'b0);
        step(1'b1, 32'h0040_006F, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);

        // Randomised traffic with random back-pressure
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom), rnd_instr(), ($urandom_range(0, 2) != 0));
        end

        // Fill both entries, then reset: nothing stale may come out afterwards
        step(1'b1, 32'h1230_0513, 1'b0);
        step(1'b1, 32'h4560_0593, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);
        step(1'b1, 32'hFFF0_0093, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
